// File: rtl/sr_mem_ctrl_pkg.sv
// Shared definitions for the per-node memory controller: AGU request codes,
// controller FSM state encodings and a small op-decode helper.
package sr_mem_ctrl_pkg;

  localparam logic [2:0] AGU_IDLE  = 3'd0;
  localparam logic [2:0] AGU_LOAD  = 3'd1;
  localparam logic [2:0] AGU_STORE = 3'd2;

  typedef enum logic [2:0] {
    MC_IDLE = 3'd0,
    MC_LRD  = 3'd1,
    MC_REQ  = 3'd2,
    MC_WAIT = 3'd3,
    MC_RESP = 3'd4
  } mc_state_e;

  // Codes 3..7 behave exactly like AGU_IDLE.
  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == AGU_LOAD) || (op == AGU_STORE);
  endfunction

endpackage

// File: rtl/sr_mem_bank.sv
// Local single-port 2^AW x 32 RAM bank with registered read data.
module sr_mem_bank #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // NOTE: the array is power-up initialised but never reset; a reset port on
  // a RAM prevents block-RAM mapping, and bank contents must survive reset.
  logic [31:0] mem [2**AW] = '{default: '0};

  // Write on we; read is registered every cycle (read-before-write).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sr_mem_ctrl.sv
// Per-node memory controller: serves AGU loads/stores from the local bank or
// forwards them over the valid/ready network port, then pulses instrSuccess.
module sr_mem_ctrl
  import sr_mem_ctrl_pkg::*;
#(
  parameter int NODE_ID = 0,
  parameter int RAM_AW  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  aguInstr,
  input  logic [31:0] ramAddress,
  input  logic [31:0] dataFromCpu,
  output logic [31:0] dataToCpu,
  output logic        instrSuccess,
  output logic        netReqValid,
  input  logic        netReqReady,
  output logic        netReqWrite,
  output logic [31:0] netReqAddr,
  output logic [31:0] netReqData,
  input  logic        netRspValid,
  input  logic [31:0] netRspData
);

  localparam logic [3:0] NODE_NIB = 4'(NODE_ID);

  mc_state_e   state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_data_q, req_data_d;
  logic        req_write_q, req_write_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic              is_local;
  logic              bank_we;
  logic [RAM_AW-1:0] bank_addr;
  logic [31:0]       bank_rdata;

  assign is_local  = (ramAddress[31:28] == NODE_NIB);
  // Bits above the word index alias onto the same bank word.
  assign bank_addr = ramAddress[RAM_AW+1:2];

  sr_mem_bank #(.AW(RAM_AW)) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .addr  (bank_addr),
    .wdata (dataFromCpu),
    .rdata (bank_rdata)
  );

  // Next-state, request capture and response capture.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; that is what keeps this block from inferring latches.
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_write_d = req_write_q;
    rsp_data_d  = rsp_data_q;
    bank_we     = 1'b0;

    unique case (state_q)
      MC_IDLE: begin
        if (is_mem_op(aguInstr)) begin
          if (is_local) begin
            if (aguInstr == AGU_STORE) begin
              bank_we    = 1'b1;
              rsp_data_d = '0;
              state_d    = MC_RESP;
            end else begin
              state_d = MC_LRD;
            end
          end else begin
            req_addr_d  = ramAddress;
            req_data_d  = dataFromCpu;
            req_write_d = (aguInstr == AGU_STORE);
            state_d     = MC_REQ;
          end
        end
      end
      MC_LRD: begin
        rsp_data_d = bank_rdata;
        state_d    = MC_RESP;
      end
      MC_REQ: begin
        if (netReqReady) begin
          state_d = MC_WAIT;
        end
      end
      MC_WAIT: begin
        if (netRspValid) begin
          rsp_data_d = req_write_q ? '0 : netRspData;
          state_d    = MC_RESP;
        end
      end
      MC_RESP: begin
        state_d = MC_IDLE;
      end
      default: begin
        state_d = MC_IDLE;
      end
    endcase
  end

  // State and captured-field registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= MC_IDLE;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_write_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_write_q <= req_write_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Outputs come only from registers, so there is no input-to-output path.
  assign instrSuccess = (state_q == MC_RESP);
  assign dataToCpu    = instrSuccess ? rsp_data_q : '0;
  assign netReqValid  = (state_q == MC_REQ);
  assign netReqWrite  = req_write_q;
  assign netReqAddr   = req_addr_q;
  assign netReqData   = req_data_q;

endmodule

// File: tb/tb_sr_mem_ctrl.sv
// Scoreboard bench for sr_mem_ctrl: a driver issues ops and pushes expected
// load data from a memory-map model; a monitor pops on every instrSuccess.
module tb_sr_mem_ctrl;
  import sr_mem_ctrl_pkg::*;

  localparam int NODE = 0;
  localparam int AW   = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  aguInstr;
  logic [31:0] ramAddress, dataFromCpu, dataToCpu;
  logic        instrSuccess, netReqValid, netReqReady, netReqWrite;
  logic [31:0] netReqAddr, netReqData, netRspData;
  logic        netRspValid;

  sr_mem_ctrl #(.NODE_ID(NODE), .RAM_AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .aguInstr     (aguInstr),
    .ramAddress   (ramAddress),
    .dataFromCpu  (dataFromCpu),
    .dataToCpu    (dataToCpu),
    .instrSuccess (instrSuccess),
    .netReqValid  (netReqValid),
    .netReqReady  (netReqReady),
    .netReqWrite  (netReqWrite),
    .netReqAddr   (netReqAddr),
    .netReqData   (netReqData),
    .netRspValid  (netRspValid),
    .netRspData   (netRspData)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int hs_seen = 0;
  int hs_exp  = 0;

  logic [31:0] exp_q [$];
  logic [31:0] local_mem  [int];
  logic [31:0] remote_mem [int];
  logic [31:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int lidx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  function automatic int rkey(input logic [31:0] a);
    return int'(a[31:2]);
  endfunction

  // Monitor: every completion pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst && instrSuccess) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("data_to_cpu", dataToCpu, mon_exp);
      end
    end
  end

  // Count accepted network requests to catch duplicated or missing ones.
  always @(negedge clk) begin
    if (!rst && netReqValid && netReqReady) hs_seen++;
  end

  // Issue one op from cycle 0 and act as the network; returns one cycle after
  // the pulse (or after a 4-cycle watch for idle ops) with inputs still held.
  task automatic do_op(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input int ready_at,
                       input int rsp_dly, input bit noise);
    bit          active, remote, done;
    int          hs, exp_lat;
    logic [31:0] exp_d, rsp_word;
    active   = (op == AGU_LOAD) || (op == AGU_STORE);
    remote   = (addr[31:28] != 4'(NODE));
    exp_d    = '0;
    rsp_word = $urandom;
    if (active) begin
      if (!remote) begin
        if (op == AGU_STORE) local_mem[lidx(addr)] = data;
        else exp_d = local_mem.exists(lidx(addr)) ? local_mem[lidx(addr)] : 32'h0;
      end else begin
        hs_exp++;
        if (op == AGU_STORE) begin
          remote_mem[rkey(addr)] = data;
        end else begin
          if (!remote_mem.exists(rkey(addr))) remote_mem[rkey(addr)] = $urandom;
          exp_d    = remote_mem[rkey(addr)];
          rsp_word = exp_d;
        end
      end
      exp_q.push_back(exp_d);
    end
    exp_lat = !active ? -1 :
              !remote ? ((op == AGU_STORE) ? 1 : 2) :
              ((ready_at < 1 ? 1 : ready_at) + rsp_dly + 1);
    aguInstr    = op;
    ramAddress  = addr;
    dataFromCpu = data;
    hs   = -1;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      netReqReady = active && remote && (c >= ready_at);
      if (hs >= 0) netRspValid = (c == hs + rsp_dly);
      else         netRspValid = noise && ($urandom_range(0, 1) == 1);
      netRspData  = (hs >= 0 && c == hs + rsp_dly) ? rsp_word : $urandom;
      @(negedge clk);
      if (active && remote) begin
        if (hs < 0 && c >= 1) begin
          check("req_valid", {31'd0, netReqValid}, 32'd1);
          check("req_addr",  netReqAddr, addr);
          check("req_write", {31'd0, netReqWrite}, {31'd0, op == AGU_STORE});
          check("req_data",  netReqData, data);
          if (netReqValid && netReqReady) hs = c;
        end else if (hs >= 0 && c == hs + 1) begin
          check("req_valid_drop", {31'd0, netReqValid}, 32'd0);
        end
      end else begin
        check("no_net_req", {31'd0, netReqValid}, 32'd0);
      end
      if (active && instrSuccess) begin
        check("latency", c, exp_lat);
        done = 1'b1;
      end
      if (!active) begin
        check("idle_no_pulse", {31'd0, instrSuccess}, 32'd0);
        if (c == 3) done = 1'b1;
      end
    end
    if (!done) check("timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    netReqReady = 1'b0;
    netRspValid = 1'b0;
  endtask

  // Reset while a remote load sits in WAIT, then feed a stray response.
  task automatic reset_mid_op();
    bit got;
    aguInstr    = AGU_LOAD;
    ramAddress  = 32'h5000_0100;
    dataFromCpu = $urandom;
    netReqReady = 1'b1;
    netRspValid = 1'b0;
    hs_exp++;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (netReqValid) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_reach_req", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
    netReqReady = 1'b0;
    aguInstr    = AGU_IDLE;
    #2 rst = 1'b1;
    #1;
    check("rst_success",   {31'd0, instrSuccess}, 32'd0);
    check("rst_data",      dataToCpu, 32'd0);
    check("rst_req_valid", {31'd0, netReqValid}, 32'd0);
    check("rst_req_write", {31'd0, netReqWrite}, 32'd0);
    check("rst_req_addr",  netReqAddr, 32'd0);
    check("rst_req_data",  netReqData, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    netRspValid = 1'b1;
    netRspData  = 32'hBAD0_BAD0;
    @(posedge clk);
    #1 netRspValid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stray_rsp_no_pulse", {31'd0, instrSuccess}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    int          r;
    rst = 1'b1;
    aguInstr = AGU_IDLE; ramAddress = '0; dataFromCpu = '0;
    netReqReady = 1'b0; netRspValid = 1'b0; netRspData = '0;
    repeat (2) @(negedge clk);
    check("reset_success",   {31'd0, instrSuccess}, 32'd0);
    check("reset_data",      dataToCpu, 32'd0);
    check("reset_req_valid", {31'd0, netReqValid}, 32'd0);
    check("reset_req_write", {31'd0, netReqWrite}, 32'd0);
    check("reset_req_addr",  netReqAddr, 32'd0);
    check("reset_req_data",  netReqData, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Local store then load of the same word.
    do_op(AGU_STORE, (32'(NODE) << 28) | 32'h10, 32'hDEAD_BEEF, 0, 1, 1'b0);
    do_op(AGU_LOAD,  (32'(NODE) << 28) | 32'h10, 32'h0, 0, 1, 1'b0);
    // Unwritten local word reads as zero.
    do_op(AGU_LOAD,  (32'(NODE) << 28) | 32'h3F0, 32'h0, 0, 1, 1'b0);
    do_op(AGU_IDLE,  32'h0, 32'h0, 0, 1, 1'b0);

    // Remote load with ready low for 3 REQ cycles, response 2 after handshake.
    remote_mem[rkey(32'h2000_0040)] = 32'h1234_5678;
    do_op(AGU_LOAD, 32'h2000_0040, 32'h0, 4, 2, 1'b1);
    // Remote store waits for its ack; ready already high in cycle 0.
    do_op(AGU_STORE, 32'h3000_0080, 32'hCAFE_F00D, 0, 3, 1'b1);
    do_op(AGU_IDLE, 32'hFFFF_FFFF, 32'h0, 0, 1, 1'b1);

    // Back-to-back: local store, local load, remote load.
    do_op(AGU_STORE, (32'(NODE) << 28) | 32'h24, 32'hA5A5_0001, 0, 1, 1'b0);
    do_op(AGU_LOAD,  (32'(NODE) << 28) | 32'h24, 32'h0, 0, 1, 1'b0);
    do_op(AGU_LOAD,  32'h3000_0080, 32'h0, 1, 1, 1'b0);

    // Idle and illegal ops must not write the bank or touch the network.
    do_op(AGU_IDLE, (32'(NODE) << 28) | 32'h10, 32'h1111_1111, 0, 1, 1'b1);
    do_op(3'd5,     (32'(NODE) << 28) | 32'h10, 32'h2222_2222, 0, 1, 1'b1);
    do_op(3'd5,     32'h7000_0000, 32'h3333_3333, 0, 1, 1'b1);
    do_op(AGU_LOAD, (32'(NODE) << 28) | 32'h10, 32'h0, 0, 1, 1'b0);
    do_op(AGU_IDLE, 32'h0, 32'h0, 0, 1, 1'b0);

    // Reset in WAIT; bank contents survive and FSM restarts in IDLE.
    reset_mid_op();
    do_op(AGU_LOAD, (32'(NODE) << 28) | 32'h10, 32'h0, 0, 1, 1'b0);

    // Randomised mix with address aliasing and spurious responses.
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1)
        a = {4'(NODE), 16'($urandom), 10'($urandom_range(0, 15)), 2'($urandom)};
      else
        a = {4'($urandom_range(1, 15)), 20'h0, 6'($urandom_range(0, 7)), 2'($urandom)};
      d = $urandom;
      if (r <= 3)      do_op(AGU_LOAD,  a, d, $urandom_range(0, 3), $urandom_range(1, 3), 1'b1);
      else if (r <= 7) do_op(AGU_STORE, a, d, $urandom_range(0, 3), $urandom_range(1, 3), 1'b1);
      else if (r == 8) do_op(AGU_IDLE,  a, d, 0, 1, 1'b1);
      else             do_op(3'($urandom_range(3, 7)), a, d, 0, 1, 1'b1);
    end
    do_op(AGU_IDLE, 32'h0, 32'h0, 0, 1, 1'b0);

    check("pending_responses", exp_q.size(), 32'd0);
    check("net_handshakes", hs_seen, hs_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
